wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stage (pipe)
//  and a long-latency result source (ll: mul/div, late loads). Pipe has priority.
//  ll results queue in a small FIFO. A starvation counter forces one FIFO drain when needed,
//  and the block exposes a hazard check against queued destinations.
//  Sits between writeback/ll units and the regfile write port and bypass network.
// PARAMETERS
//  DEPTH       2   ll result FIFO entries (>=1)
//  STARVE_MAX  4   consecutive pipe wins over a non-empty FIFO before one forced FIFO drain (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  pipe_valid      in   1   writeback stage presents a result
//  pipe_rd         in   5   writeback destination register
//  pipe_data       in   32  writeback value
//  pipe_ready      out  1   pipe result consumed this cycle; 0 = writeback stage must hold
//  ll_valid        in   1   long-latency unit presents a result
//  ll_rd           in   5   ll destination register
//  ll_data         in   32  ll value
//  ll_ready        out  1   FIFO accepts ll result at this edge
//  hz_rs1, hz_rs2  in   5   source registers of the instruction in decode
//  hz_hit          out  1   a nonzero hz_rs* matches the rd of any queued FIFO entry
//  regfile_w_en    out  1   regfile write strobe
//  regfile_w_reg   out  5   regfile write register
//  regfile_w_data  out  32  regfile write data
//  wb_bp_reg       out  5   bypass register (= regfile_w_reg)
//  wb_bp_val       out  32  bypass value (= regfile_w_data)
// BEHAVIOUR
//  State: FIFO (count 0..DEPTH, rd/ptr), starve_cnt, FSM {PIPE_PRI, FORCE}.
//  Reset values: count=0, ptrs=0, starve_cnt=0, state=PIPE_PRI.
//  rst mid-operation discards all queued entries. Nothing queued is ever written after reset.
//  All outputs are combinational from state and inputs; a write is performed in the same cycle it is granted.
//  pipe_req = pipe_valid && pipe_rd!=0. rd=0 results are never written.
//  A pipe result with rd=0 is still consumed when pipe_ready=1.
//  ll_ready = !rst && count<DEPTH. It does not depend on ll_valid. There is no full-FIFO pass-through.
//  Enqueue at the edge when ll_valid && ll_ready && ll_rd!=0.
//  An ll result with rd=0 is accepted and dropped.
//  An entry is writable no earlier than the cycle after its enqueue. The FIFO is never bypassed.
//  Grant per cycle:
//   - FIFO empty: pipe wins if pipe_req.
//   - FIFO non-empty, state=FORCE: FIFO head wins.
//   - FIFO non-empty, PIPE_PRI, pipe_req: pipe wins.
//   - FIFO non-empty, PIPE_PRI, !pipe_req: FIFO head wins.
//   - FIFO wins -> head dequeued at the edge.
//  Winner drives regfile_w_en=1 with its rd/data.
//  No winner: regfile_w_en=0, w_reg=0, w_data=0. Bypass outputs mirror w_reg/w_data.
//  pipe_ready = (state!=FORCE).
//  starve_cnt: +1 at each edge where pipe wins over a non-empty FIFO.
//   It clears when the FIFO wins or the FIFO is empty.
//  PIPE_PRI->FORCE when pipe wins over a non-empty FIFO with starve_cnt==STARVE_MAX-1 (cnt->0).
//  FORCE->PIPE_PRI unconditionally after one cycle. FORCE always drains exactly one entry.
//  Simultaneous enqueue+dequeue with count<DEPTH: count unchanged, both pointers advance.
//  Pointers wrap modulo DEPTH.
//  hz_hit is computed over valid entries only, including the head being written this cycle.
//  hz_rs==0 never hits.
// TESTING
//  T1: after reset, ll_valid rd=5 data=0xDEADBEEF one cycle, pipe idle
//      -> next cycle w_en=1, w_reg=5, w_data=0xDEADBEEF; then count=0, ll_ready=1.
//  T2: pipe_req rd=3 every cycle, one ll entry rd=7 queued
//      -> pipe written 4 cycles; 5th cycle w_reg=7, pipe_ready=0; 6th cycle w_reg=3 again.
//  T3: pipe busy, enqueue rd=8, rd=9
//      -> ll_ready=0 and a held ll_valid rd=10 is not accepted until an entry drains.
//      -> writes then occur in order 8,9,10.
//  T4: pipe rd=0 and ll rd=0 together -> w_en=0, pipe_ready=1, count stays 0.
//  T5: rd=9 queued, hz_rs1=9 -> hz_hit=1. hz_rs2=0 alone -> 0.
//      After the rd=9 write cycle, hz_hit=0.
//  T6: two entries queued, state=FORCE, assert rst mid-cycle
//      -> immediately count=0, w_en=0, pipe_ready=1, ll_ready=0.
//      -> after release, ll_ready=1 and no stale write occurs.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage (pipe) and a long-latency result source (ll). The pipe has priority.
//   ll results wait in a small FIFO. A starvation counter forces one FIFO drain
//   after STARVE_MAX consecutive pipe wins over a non-empty FIFO. A hazard
//   check flags decode sources that match the rd of any queued entry.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pipe_valid/_rd/_data          writeback stage result
//   pipe_ready                    pipe result consumed this cycle
//   ll_valid/_rd/_data            long-latency result
//   ll_ready                      FIFO accepts an ll result at this edge
//   hz_rs1, hz_rs2, hz_hit        decode-stage hazard check against the FIFO
//   regfile_w_en/_reg/_data       register-file write port
//   wb_bp_reg, wb_bp_val          bypass copy of the write port
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic [4:0]  hz_rs1,
  input  logic [4:0]  hz_rs2,
  output logic        hz_hit,
  output logic        regfile_w_en,
  output logic [4:0]  regfile_w_reg,
  output logic [31:0] regfile_w_data,
  output logic [4:0]  wb_bp_reg,
  output logic [31:0] wb_bp_val
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);
  localparam logic [SC_W-1:0]  STARVE_LAST = SC_W'(STARVE_MAX - 1);

  typedef enum logic {PIPE_PRI, FORCE} state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH-1:0]  valid_q;
  logic [4:0]        rd_q   [DEPTH];
  logic [31:0]       data_q [DEPTH];

  logic fifo_empty, pipe_req, enq, fifo_win, pipe_win, pipe_over;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count == '0);
  assign pipe_req   = pipe_valid && (pipe_rd != '0);
  assign pipe_ready = (state != FORCE);
  assign ll_ready   = !rst && (count < DEPTH_C);
  // rd=0 ll results are acknowledged through ll_ready but never stored.
  assign enq        = ll_valid && ll_ready && (ll_rd != '0);
  assign fifo_win   = !fifo_empty && ((state == FORCE) || !pipe_req);
  assign pipe_win   = pipe_req && pipe_ready && !fifo_win;
  assign pipe_over  = pipe_win && !fifo_empty;

  always_comb begin
    regfile_w_en   = 1'b0;
    regfile_w_reg  = '0;
    regfile_w_data = '0;
    if (fifo_win) begin
      regfile_w_en   = 1'b1;
      regfile_w_reg  = rd_q[rd_ptr];
      regfile_w_data = data_q[rd_ptr];
    end else if (pipe_win) begin
      regfile_w_en   = 1'b1;
      regfile_w_reg  = pipe_rd;
      regfile_w_data = pipe_data;
    end
  end

  assign wb_bp_reg = regfile_w_reg;
  assign wb_bp_val = regfile_w_data;

  // Hazard check covers every valid entry, including a head being written now.
  always_comb begin
    hz_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (((hz_rs1 != '0) && (rd_q[i] == hz_rs1)) ||
                         ((hz_rs2 != '0) && (rd_q[i] == hz_rs2))))
        hz_hit = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation FSM: FORCE lasts exactly one cycle and drains one entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    case (state)
      PIPE_PRI: begin
        if (pipe_over) begin
          if (starve_cnt == STARVE_LAST) state_nxt  = FORCE;
          else                           starve_nxt = starve_cnt + 1'b1;
        end
      end
      FORCE:    state_nxt = PIPE_PRI;
      default:  state_nxt = PIPE_PRI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PIPE_PRI;
      starve_cnt <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_q    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (fifo_win) begin
        rd_ptr          <= ptr_inc(rd_ptr);
        valid_q[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        wr_ptr          <= ptr_inc(wr_ptr);
        valid_q[wr_ptr] <= 1'b1;
      end
      case ({enq, fifo_win})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload storage has no reset; valid_q and count qualify every
  // read, so stale contents after reset are never observable.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[wr_ptr]   <= ll_rd;
      data_q[wr_ptr] <= ll_data;
    end
  end

endmodule
